// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage around an 8-bit combinational ALU: registers one operation onto the
// ALU inputs, captures the result one cycle later, and holds it until the consumer takes it.
module alu_issue_ctrl #(
  parameter int CNT_W    = 8,
  parameter bit CHAIN_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [2:0]       in_op,
  input  logic             in_cin,
  input  logic             in_chain,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  input  logic [7:0]       alu_out,
  input  logic             alu_cout,
  input  logic             alu_c,
  input  logic             alu_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_cout,
  output logic             res_c,
  output logic             res_z,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_consume;

  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [2:0]       r_alu_op;
  logic             r_alu_cin;
  logic             r_carry_sav;
  logic [7:0]       r_res_data;
  logic             r_res_cout;
  logic             r_res_c;
  logic             r_res_z;
  logic [CNT_W-1:0] r_op_count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // in_ready is combinational from res_ready so a consume and a new accept can share a cycle.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_EXEC;
      end
      S_EXEC: begin
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        in_ready  = res_ready;
        w_consume = res_ready;
        if (res_ready) w_state_next = in_valid ? S_EXEC : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_accept = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a     <= 8'd0;
      r_alu_b     <= 8'd0;
      r_alu_op    <= 3'b000;
      r_alu_cin   <= 1'b0;
      r_carry_sav <= 1'b0;
      r_res_data  <= 8'd0;
      r_res_cout  <= 1'b0;
      r_res_c     <= 1'b0;
      r_res_z     <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a   <= in_a;
        r_alu_b   <= in_b;
        r_alu_op  <= in_op;
        r_alu_cin <= (CHAIN_EN && in_chain) ? r_carry_sav : in_cin;
      end
      if (r_state == S_EXEC) begin
        r_res_data <= alu_out;
        r_res_cout <= alu_cout;
        r_res_c    <= alu_c;
        r_res_z    <= alu_z;
        // Only add/sub feed the chain; logic and shift carries are not meaningful across bytes.
        if (r_alu_op == 3'b000 || r_alu_op == 3'b001) r_carry_sav <= alu_cout;
      end
      if (w_consume) r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign alu_cin   = r_alu_cin;
  assign res_valid = (r_state == S_HOLD);
  assign res_data  = r_res_data;
  assign res_cout  = r_res_cout;
  assign res_c     = r_res_c;
  assign res_z     = r_res_z;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Drives three copies of the issue stage (chained, unchained, 2-bit counter) with identical
// stimulus, each with its own behavioural ALU, and compares against a transaction model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;
  logic [2:0] in_op = 3'd0;
  logic       in_cin = 1'b0;
  logic       in_chain = 1'b0;
  logic       res_ready = 1'b0;

  logic       in_ready_w [3];
  logic [7:0] alu_a_w    [3];
  logic [7:0] alu_b_w    [3];
  logic [2:0] alu_op_w   [3];
  logic       alu_cin_w  [3];
  logic [7:0] alu_out_w  [3];
  logic       alu_cout_w [3];
  logic       alu_c_w    [3];
  logic       alu_z_w    [3];
  logic       res_valid_w[3];
  logic [7:0] res_data_w [3];
  logic       res_cout_w [3];
  logic       res_c_w    [3];
  logic       res_z_w    [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: returns {out[7:0], carry_out, C_flag, Z_flag}.
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic cin);
    int s;
    logic [7:0] o;
    logic co, cf;
    co = 1'b0; cf = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b) + int'(cin); o = s[7:0]; co = (s > 255); cf = co; end
      3'd1: begin s = int'(a) - int'(b) - int'(cin); o = s[7:0]; co = (s < 0);   cf = co; end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: begin o = (a > b) ? 8'd1 : 8'd0; cf = (a > b); end
      3'd6: begin o = a << 1; co = a[7]; cf = a[7]; end
      default: begin o = b << 1; co = b[7]; cf = b[7]; end
    endcase
    return {o, co, cf, (o == 8'd0)};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_alu
    assign {alu_out_w[gi], alu_cout_w[gi], alu_c_w[gi], alu_z_w[gi]} =
      alu_f(alu_a_w[gi], alu_b_w[gi], alu_op_w[gi], alu_cin_w[gi]);
  end

  alu_issue_ctrl #(.CNT_W(8), .CHAIN_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_chain(in_chain),
    .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_op(alu_op_w[0]), .alu_cin(alu_cin_w[0]),
    .alu_out(alu_out_w[0]), .alu_cout(alu_cout_w[0]), .alu_c(alu_c_w[0]), .alu_z(alu_z_w[0]),
    .res_valid(res_valid_w[0]), .res_ready(res_ready), .res_data(res_data_w[0]),
    .res_cout(res_cout_w[0]), .res_c(res_c_w[0]), .res_z(res_z_w[0]), .op_count(cnt0));

  alu_issue_ctrl #(.CNT_W(8), .CHAIN_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_chain(in_chain),
    .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_op(alu_op_w[1]), .alu_cin(alu_cin_w[1]),
    .alu_out(alu_out_w[1]), .alu_cout(alu_cout_w[1]), .alu_c(alu_c_w[1]), .alu_z(alu_z_w[1]),
    .res_valid(res_valid_w[1]), .res_ready(res_ready), .res_data(res_data_w[1]),
    .res_cout(res_cout_w[1]), .res_c(res_c_w[1]), .res_z(res_z_w[1]), .op_count(cnt1));

  alu_issue_ctrl #(.CNT_W(2), .CHAIN_EN(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_chain(in_chain),
    .alu_a(alu_a_w[2]), .alu_b(alu_b_w[2]), .alu_op(alu_op_w[2]), .alu_cin(alu_cin_w[2]),
    .alu_out(alu_out_w[2]), .alu_cout(alu_cout_w[2]), .alu_c(alu_c_w[2]), .alu_z(alu_z_w[2]),
    .res_valid(res_valid_w[2]), .res_ready(res_ready), .res_data(res_data_w[2]),
    .res_cout(res_cout_w[2]), .res_c(res_c_w[2]), .res_z(res_z_w[2]), .op_count(cnt2));

  // Transaction-level model state
  bit          chain_en [3] = '{1'b1, 1'b0, 1'b1};
  int          cnt_mod  [3] = '{256, 256, 4};
  logic        m_carry  [3];
  int          m_count  [3];
  logic [7:0]  m_a, m_b;
  logic [2:0]  m_op;
  logic        m_cin    [3];
  logic [10:0] m_res    [3];
  bit          pending;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_cnt(input int i);
    if (i == 0) return 32'(cnt0);
    if (i == 1) return 32'(cnt1);
    return 32'(cnt2);
  endfunction

  task automatic chk_cnt(input string tag);
    for (int i = 0; i < 3; i++) chk({tag, "_cnt"}, i, get_cnt(i), 32'(m_count[i] % cnt_mod[i]));
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    for (int i = 0; i < 3; i++) chk({tag, "_in_ready"}, i, 32'(in_ready_w[i]), 32'(exp));
  endtask

  task automatic chk_alu(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_alu_a"},   i, 32'(alu_a_w[i]),   32'(m_a));
      chk({tag, "_alu_b"},   i, 32'(alu_b_w[i]),   32'(m_b));
      chk({tag, "_alu_op"},  i, 32'(alu_op_w[i]),  32'(m_op));
      chk({tag, "_alu_cin"}, i, 32'(alu_cin_w[i]), 32'(m_cin[i]));
    end
  endtask

  task automatic chk_res(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_res_valid"}, i, 32'(res_valid_w[i]), 32'd1);
      chk({tag, "_res_data"},  i, 32'(res_data_w[i]),  32'(m_res[i][10:3]));
      chk({tag, "_res_cout"},  i, 32'(res_cout_w[i]),  32'(m_res[i][2]));
      chk({tag, "_res_c"},     i, 32'(res_c_w[i]),     32'(m_res[i][1]));
      chk({tag, "_res_z"},     i, 32'(res_z_w[i]),     32'(m_res[i][0]));
    end
  endtask

  // Entry/exit point of every task: 1 time unit after a rising edge.
  task automatic issue(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic cin, input logic chain);
    in_a = a; in_b = b; in_op = op; in_cin = cin; in_chain = chain;
    in_valid = 1'b1; res_ready = pending;
    @(negedge clk);
    chk_ready({tag, "_acc"}, 1'b1);
    if (pending) chk_res({tag, "_cons"});
    chk_cnt({tag, "_acc"});
    @(posedge clk);
    if (pending) for (int i = 0; i < 3; i++) m_count[i]++;
    pending = 1'b0;
    m_a = a; m_b = b; m_op = op;
    for (int i = 0; i < 3; i++) m_cin[i] = (chain_en[i] && chain) ? m_carry[i] : cin;
    #1;
    in_valid = 1'b0; res_ready = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom); in_chain = 1'($urandom);
    @(negedge clk);
    chk_ready({tag, "_exec"}, 1'b0);
    for (int i = 0; i < 3; i++) chk({tag, "_exec_res_valid"}, i, 32'(res_valid_w[i]), 32'd0);
    chk_alu({tag, "_exec"});
    chk_cnt({tag, "_exec"});
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_res[i] = alu_f(m_a, m_b, m_op, m_cin[i]);
      if (m_op <= 3'd1) m_carry[i] = m_res[i][2];
    end
    pending = 1'b1;
    #1;
    $display("op %s a=%0d b=%0d op=%0d cin=%0d chain=%0d -> u0 %0d u1 %0d u2 %0d",
             tag, a, b, op, cin, chain, m_res[0][10:3], m_res[1][10:3], m_res[2][10:3]);
  endtask

  task automatic stall(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'($urandom); in_a = 8'($urandom);
      @(negedge clk);
      chk_ready({tag, "_stall"}, 1'b0);
      chk_res({tag, "_stall"});
      chk_alu({tag, "_stall"});
      chk_cnt({tag, "_stall"});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    res_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk_ready({tag, "_drain"}, 1'b1);
    chk_res({tag, "_drain"});
    @(posedge clk);
    for (int i = 0; i < 3; i++) m_count[i]++;
    pending = 1'b0;
    #1 res_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk({tag, "_idle_res_valid"}, i, 32'(res_valid_w[i]), 32'd0);
    chk_ready({tag, "_idle"}, 1'b1);
    chk_cnt({tag, "_idle"});
    @(posedge clk); #1;
  endtask

  // Reset asserted with handshakes active to show it takes priority.
  task automatic do_reset(input string tag);
    rst = 1'b1; in_valid = 1'b1; res_ready = 1'b1; in_a = 8'hA5; in_op = 3'd4;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    pending = 1'b0; m_a = 8'd0; m_b = 8'd0; m_op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      m_carry[i] = 1'b0; m_count[i] = 0; m_cin[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_res_valid"}, i, 32'(res_valid_w[i]), 32'd0);
      chk({tag, "_res_data"},  i, 32'(res_data_w[i]),  32'd0);
      chk({tag, "_res_flags"}, i, 32'({res_cout_w[i], res_c_w[i], res_z_w[i]}), 32'd0);
    end
    chk_alu(tag);
    chk_cnt(tag);
    chk_ready(tag, 1'b1);
    @(posedge clk); #1;
    $display("reset %s done", tag);
  endtask

  initial begin
    do_reset("por");

    issue("add", 8'd170, 8'd108, 3'd0, 1'b0, 1'b0);
    drain("add");
    issue("chain", 8'd7, 8'd4, 3'd0, 1'b0, 1'b1);
    drain("chain");

    issue("bp", 8'd200, 8'd100, 3'd1, 1'b1, 1'b0);
    stall("bp", 5);
    issue("xor", 8'd255, 8'd9, 3'd4, 1'b0, 1'b0);
    drain("xor");

    issue("zero", 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    drain("zero");
    issue("and", 8'd255, 8'd0, 3'd2, 1'b0, 1'b0);
    drain("and");
    issue("chz", 8'd7, 8'd0, 3'd0, 1'b0, 1'b1);
    drain("chz");
    issue("addnc", 8'd1, 8'd2, 3'd0, 1'b0, 1'b0);
    issue("shl", 8'h80, 8'd3, 3'd6, 1'b0, 1'b0);
    issue("chs", 8'd9, 8'd9, 3'd0, 1'b1, 1'b1);
    drain("chs");

    for (int n = 0; n < 40; n++) begin
      issue("rnd", 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom));
      stall("rnd", $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) drain("rnd");
    end
    if (pending) drain("rnd_end");

    in_a = 8'd50; in_b = 8'd60; in_op = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    do_reset("rst_exec");
    issue("pre_hold", 8'd90, 8'd91, 3'd3, 1'b0, 1'b0);
    stall("pre_hold", 1);
    do_reset("rst_hold");

    for (int n = 0; n < 5; n++) begin
      issue("wrap", 8'(n), 8'(n + 1), 3'd0, 1'b0, 1'b1);
      drain("wrap");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
